// File: rtl/exec_pipe_unit.sv
// Two-stage execute unit: stage 1 holds the accepted instruction, stage 2 holds
// the registered ALU result, with valid/ready flow control on both sides.
module exec_pipe_unit #(
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int CARRY_CHAIN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o,
    output logic [DATA_W-1:0] d_out,
    output logic              cout,
    output logic              op_err
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;

    logic              s1_valid;
    logic [31:0]       s1_instr;
    logic              s1_cin;
    logic              s1_advance;
    logic              fire;
    logic              carry_flag;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [3:0]        op;
    logic [AW-1:0]     dst;
    logic              wb;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              c_in;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_o;
    logic              alu_c;
    logic              is_alu;
    logic              is_arith;
    logic              is_err;

    // Instruction fields that the datapath does not decode are latched but unused.
    logic unused_instr_bits;
    assign unused_instr_bits = ^s1_instr;

    assign op   = s1_instr[31:28];
    assign dst  = s1_instr[24 +: AW];
    assign wb   = s1_instr[23];
    assign opb  = s1_instr[DATA_W +: DATA_W];
    assign opa  = s1_instr[0 +: DATA_W];

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign fire       = s1_valid && s1_advance;

    assign c_in = (CARRY_CHAIN != 0) ? carry_flag : s1_cin;
    assign sum  = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, c_in};
    assign diff = {1'b0, opa} - {1'b0, opb} - {{DATA_W{1'b0}}, c_in};

    always_comb begin
        alu_o    = '0;
        alu_c    = 1'b0;
        is_alu   = 1'b1;
        is_arith = 1'b0;
        is_err   = (op > OP_LOAD);
        case (op)
            OP_ADD: begin
                alu_o    = sum[DATA_W-1:0];
                alu_c    = sum[DATA_W];
                is_arith = 1'b1;
            end
            OP_SUB: begin
                alu_o    = diff[DATA_W-1:0];
                alu_c    = diff[DATA_W];
                is_arith = 1'b1;
            end
            OP_AND: alu_o = opa & opb;
            OP_OR:  alu_o = opa | opb;
            OP_XOR: alu_o = opa ^ opb;
            OP_SHL: begin
                alu_o = {opa[DATA_W-2:0], 1'b0};
                alu_c = opa[DATA_W-1];
            end
            OP_SHR: begin
                alu_o = {1'b0, opa[DATA_W-1:1]};
                alu_c = opa[0];
            end
            default: is_alu = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_cin   <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_instr <= instr;
            s1_cin   <= cin;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // NOP retires from stage 1 without ever presenting a result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            o          <= '0;
            d_out      <= '0;
            cout       <= 1'b0;
            op_err     <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            if (fire && (op != OP_NOP)) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (fire) begin
                if (is_alu) begin
                    o      <= alu_o;
                    cout   <= alu_c;
                    op_err <= 1'b0;
                    if (wb) begin
                        d_out <= alu_o;
                    end
                    if (is_arith) begin
                        carry_flag <= alu_c;
                    end
                end else if (op == OP_LOAD) begin
                    d_out  <= mem[dst];
                    op_err <= 1'b0;
                end else if (is_err) begin
                    op_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (fire && is_alu && wb) begin
            mem[dst] <= alu_o;
        end
    end

endmodule

// File: tb/tb_exec_pipe_unit.sv
// Scoreboard bench for exec_pipe_unit: two instances (carry chain off/on) share
// one stimulus stream and are checked against an arithmetic reference model.
module tb_exec_pipe_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, cout0, op_err0;
    logic [7:0]  o0, d0;
    logic        in_ready1, out_valid1, cout1, op_err1;
    logic [7:0]  o1, d1;

    exec_pipe_unit #(.DATA_W(8), .MEM_DEPTH(16), .CARRY_CHAIN(0)) u_dut0 (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .in_ready(in_ready0), .cin(cin), .out_valid(out_valid0),
        .out_ready(out_ready), .o(o0), .d_out(d0), .cout(cout0), .op_err(op_err0)
    );

    exec_pipe_unit #(.DATA_W(8), .MEM_DEPTH(16), .CARRY_CHAIN(1)) u_dut1 (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .in_ready(in_ready1), .cin(cin), .out_valid(out_valid1),
        .out_ready(out_ready), .o(o1), .d_out(d1), .cout(cout1), .op_err(op_err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o0; int c0; int d0;
        int o1; int c1; int d1;
        int err;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_bp = 0;

    int   m_o[2], m_c[2], m_d[2], m_cf[2];
    int   m_err;
    int   m_mem[2][16];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_err = 0;
        for (int k = 0; k < 2; k++) begin
            m_o[k] = 0; m_c[k] = 0; m_d[k] = 0; m_cf[k] = 0;
            for (int j = 0; j < 16; j++) m_mem[k][j] = 0;
        end
    endtask

    // Applies one accepted instruction in program order and queues its result.
    task automatic model_step(input int op, input int dst, input int wb,
                              input int a, input int b, input int ci);
        exp_t e;
        int c, s, no, nc;
        if (op == 0) return;
        for (int k = 0; k < 2; k++) begin
            c  = (k == 1) ? m_cf[1] : ci;
            no = m_o[k];
            nc = m_c[k];
            case (op)
                1: begin s = a + b + c; no = s % 256; nc = (s > 255); m_cf[k] = nc; end
                2: begin s = a - b - c; no = (s + 512) % 256; nc = (s < 0); m_cf[k] = nc; end
                3: begin no = a & b; nc = 0; end
                4: begin no = a | b; nc = 0; end
                5: begin no = a ^ b; nc = 0; end
                6: begin no = (a * 2) % 256; nc = (a >= 128); end
                7: begin no = a / 2; nc = a % 2; end
                8: m_d[k] = m_mem[k][dst];
                default: ;
            endcase
            if (op >= 1 && op <= 7) begin
                m_o[k] = no;
                m_c[k] = nc;
                if (wb != 0) begin
                    m_mem[k][dst] = no;
                    m_d[k] = no;
                end
            end
        end
        m_err = (op >= 9) ? 1 : 0;
        e.o0 = m_o[0]; e.c0 = m_c[0]; e.d0 = m_d[0];
        e.o1 = m_o[1]; e.c1 = m_c[1]; e.d1 = m_d[1];
        e.err = m_err;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input int op, input int dst, input int wb,
                         input int a, input int b, input int ci);
        bit acc;
        logic [6:0] junk;
        junk = 7'($urandom);
        instr = {op[3:0], dst[3:0], wb[0], junk, b[7:0], a[7:0]};
        cin = ci[0];
        in_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready0;
            tick();
        end
        in_valid = 1'b0;
        cin = $urandom_range(0, 1);
        if (acc) model_step(op, dst, wb, a, b, ci);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Monitor: pops an expectation on every handshake; checks output hold under stall.
    bit          stall_prev = 0;
    logic [17:0] snap0, snap1;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_dut0", {o0, d0, cout0, op_err0}, snap0);
                chk("stall_hold_dut1", {o1, d1, cout1, op_err1}, snap1);
            end
            if (out_valid1 && !out_valid0) chk("dut1_unexpected_valid", 1, 0);
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("dut0_o", o0, e.o0);
                    chk("dut0_cout", cout0, e.c0);
                    chk("dut0_d_out", d0, e.d0);
                    chk("dut0_op_err", op_err0, e.err);
                    chk("dut1_valid", out_valid1, 1);
                    chk("dut1_o", o1, e.o1);
                    chk("dut1_cout", cout1, e.c1);
                    chk("dut1_d_out", d1, e.d1);
                    chk("dut1_op_err", op_err1, e.err);
                end
            end
            stall_prev = out_valid0 && !out_ready;
            snap0 = {o0, d0, cout0, op_err0};
            snap1 = {o1, d1, cout1, op_err1};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] hold0;
        int r, op;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o", o0, 0);
        chk("rst_d_out", d0, 0);
        chk("rst_cout", cout0, 0);
        chk("rst_op_err", op_err0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid_cc", out_valid1, 0);
        chk("rst_o_cc", o1, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();

        // basic ALU and latency
        issue(1, 0, 0, 'h10, 'h08, 0);
        @(negedge clk);
        chk("latency_early", out_valid0, 0);
        tick();
        chk("latency", out_valid0, 1);
        chk("add_o", o0, 'h18);
        issue(1, 0, 0, 'hFF, 'h01, 0);
        issue(2, 0, 0, 'h05, 'h07, 0);
        idle(2);
        chk("sub_o", o0, 'hFE);
        chk("sub_borrow", cout0, 1);

        // write-back then LOAD
        issue(1, 5, 1, 'h21, 'h03, 0);
        issue(8, 5, 0, 0, 0, 0);
        issue(8, 6, 0, 0, 0, 0);
        idle(2);
        chk("load_o_hold", o0, 'h24);
        chk("load_empty", d0, 'h00);

        // back-pressure with three ADDs in flight
        out_ready = 1'b0;
        fork
            begin
                issue(1, 0, 0, 'h01, 'h02, 0);
                issue(1, 0, 0, 'h03, 'h04, 1);
                issue(1, 0, 0, 'h05, 'h06, 0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                hold0 = {o0, d0, cout0, op_err0};
                chk("bp_in_ready_low", in_ready0, 0);
                chk("bp_out_valid", out_valid0, 1);
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_in_ready_held", in_ready0, 0);
                    chk("bp_out_stable", {o0, d0, cout0, op_err0}, hold0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_drain_valid", out_valid0, 1);
                end
            end
        join
        idle(3);

        // carry chain: AND between ADDs leaves the flag alone
        issue(1, 0, 0, 'hFF, 'h01, 0);
        issue(3, 0, 0, 'hF0, 'h0F, 0);
        issue(1, 2, 1, 'h00, 'h00, 0);
        tick();
        chk("cc_o", o1, 'h01);
        chk("nocc_o", o0, 'h00);

        // illegal opcode
        issue(12, 0, 0, 'h55, 'h66, 0);
        tick();
        chk("illegal_valid", out_valid0, 1);
        chk("illegal_op_err", op_err0, 1);
        chk("illegal_o_hold", o1, 'h01);
        chk("illegal_d_hold", d1, 'h01);
        issue(4, 0, 0, 'h0C, 'h30, 0);
        tick();
        chk("legal_clears_err", op_err0, 0);
        chk("or_o", o0, 'h3C);

        // asynchronous reset with two instructions in flight
        issue(1, 3, 1, 'h11, 'h22, 0);
        idle(2);
        out_ready = 1'b0;
        issue(1, 0, 0, 'h40, 'h01, 0);
        issue(1, 0, 0, 'h50, 'h02, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid0, 0);
        chk("arst_o", o0, 0);
        chk("arst_d_out", d0, 0);
        chk("arst_cout", cout0, 0);
        chk("arst_op_err", op_err0, 0);
        chk("arst_o_cc", o1, 0);
        model_reset();
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_reset", out_valid0, 0);
        end
        tick();
        issue(8, 3, 0, 0, 0, 0);
        tick();
        chk("mem_cleared", d0, 0);
        chk("mem_cleared_cc", d1, 0);
        idle(2);

        // randomized traffic with random back-pressure
        rand_bp = 1;
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            r = $urandom_range(0, 21);
            op = (r < 16) ? r : (r - 15);
            issue(op, $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        end
        rand_bp = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int n = 0; n < 100 && q.size() > 0; n++) tick();
        chk("drain_empty", q.size(), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
